// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - SPI responder emulating a 12-bit serial ADC with MOSI loopback capture
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         sample_valid,
  input  logic                         sck,
  input  logic                         cs,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_abort,
  output logic [LEAD_ZEROS+DATA_W-1:0] rx_data,
  output logic                         rx_valid
);

  localparam int          F     = LEAD_ZEROS + DATA_W;
  localparam logic [4:0]  F_CNT = 5'(F);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES:0]   settle;
  logic                   armed;
  logic [DATA_W-1:0]      holding;
  logic [F-1:0]           tx_shift, rx_shift;
  logic [4:0]             bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // A cs low level left over from reset must be seen high before a fall can start a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && cs_s && cs_d)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall && armed) state_next = SHIFT;
      SHIFT: begin
        if (cs_rise)
          state_next = IDLE;
        else if (sck_fall && bit_cnt == F_CNT)
          state_next = TAIL;
      end
      TAIL:    if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holding     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (sample_valid)
        holding <= sample_in;
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            tx_shift <= {{LEAD_ZEROS{1'b0}}, holding};
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt == F_CNT) begin
              rx_data    <= rx_shift;
              rx_valid   <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              frame_abort <= 1'b1;
            end
          end else begin
            if (sck_rise && bit_cnt < F_CNT) begin
              rx_shift <= {rx_shift[F-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 5'd1;
            end
            // The leading CPOL=1 fall keeps the MSB presented since cs fell.
            if (sck_fall && bit_cnt != 5'd0 && bit_cnt < F_CNT)
              tx_shift <= {tx_shift[F-2:0], 1'b0};
          end
        end
        TAIL: begin
          if (cs_rise) begin
            rx_data    <= rx_shift;
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    miso    = 1'b0;
    miso_oe = 1'b0;
    busy    = 1'b0;
    if (state != IDLE) begin
      miso_oe = 1'b1;
      busy    = 1'b1;
    end
    if (state == SHIFT)
      miso = tx_shift[F-1];
  end

endmodule
